snake_sprite_compositor: RTL and testbench
==========================================

SNAKE_SPRITE_COMPOSITOR -- requirements
Module: snake_sprite_compositor

Interface
REQ-001 Parameter NUM_SNAKES, default 2: number of snake heads composited, legal 1..4.
REQ-002 Parameter SPRITE_DIM, default 24: square sprite edge in pixels, even, legal 8..64.
REQ-003 Parameter COORD_W, default 10: width of DrawX/DrawY and head positions.
REQ-004 Parameter ADDR_W, default $clog2(SPRITE_DIM*SPRITE_DIM): sprite ROM address width.
REQ-005 Clk  in  1  single system/pixel clock; all state on rising edge.
REQ-006 Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 keycode  in  16  two USB HID keycodes, [7:0] and [15:8], 8'h00 = none.
REQ-008 DrawX, DrawY  in  COORD_W each  current pixel coordinate.
REQ-009 blank  in  1  1 = active video, 0 = blanking.
REQ-010 snake_x, snake_y  in  NUM_SNAKES*COORD_W each  head centre, snake i at [i*COORD_W +: COORD_W].
REQ-011 snake_alive  in  NUM_SNAKES  1 = head drawn.
REQ-012 bg_red, bg_green, bg_blue  in  4 each  background colour for the pixel presented this cycle.
REQ-013 sprite_addr  out  ADDR_W  combinational address into the shared head sprite memory.
REQ-014 sprite_dir  out  2  combinational direction select: 0 up, 1 left, 2 down, 3 right.
REQ-015 sprite_sel  out  2  combinational index of the snake being addressed.
REQ-016 sprite_red, sprite_green, sprite_blue  in  4 each  sprite colour, valid one Clk after address.
REQ-017 red, green, blue  out  4 each  registered composited pixel.
REQ-018 dir_state  out  2*NUM_SNAKES  registered active direction per snake.

Function
REQ-019 Key map (up/left/down/right): snake0 1A/04/16/07, snake1 52/50/51/4F, snake2 0C/0D/0E/0F, snake3 60/5C/5A/5E; codes for snakes >= NUM_SNAKES are ignored.
REQ-020 Each snake has a pending direction register updated on any Clk where a mapped key is present in either keycode byte.
REQ-021 If both bytes map to the same snake in one cycle, byte [7:0] wins.
REQ-022 A key requesting the exact opposite of the snake's active direction is ignored (no 180-degree reversal).
REQ-023 Active direction loads from pending only on the cycle DrawX==0 and DrawY==0, so a frame never mixes orientations.
REQ-024 Hit test for snake i: alive and x-SPRITE_DIM/2 <= DrawX <= x+SPRITE_DIM/2-1, same on Y, evaluated in COORD_W+1-bit signed arithmetic so heads near 0 or the max coordinate clip without wrap.
REQ-025 On overlap, lowest-index hitting snake is selected.
REQ-026 sprite_addr = (DrawY-y+SPRITE_DIM/2)*SPRITE_DIM + (DrawX-x+SPRITE_DIM/2) for the selected snake; sprite_dir = its active direction; sprite_sel = its index.
REQ-027 With no hit, sprite_addr, sprite_dir and sprite_sel are 0.
REQ-028 Stage 1 register: hit flag, blank, bg colour; stage 2 register: output pixel; latency from DrawX/DrawY/bg to red/green/blue is exactly 2 Clk.
REQ-029 Stage 2: blank==0 -> 0,0,0; hit and sprite colour != (F,0,F) -> sprite colour; otherwise bg colour.
REQ-030 Colour key F,0,F is transparent for every snake and direction.

Reset
REQ-031 Reset_n low asynchronously clears red/green/blue, pipeline stage registers and hit flags to 0.
REQ-032 Reset sets active and pending directions: snake0 right (3), snake1 left (1), snake2 down (2), snake3 up (0).
REQ-033 Reset asserted mid-frame: outputs read 0 within the same cycle; after release the first valid pixel appears 2 Clk after its inputs; directions stay at reset values until the next frame origin.

Verification
REQ-034 Reset, snake0 at (100,100), alive=1, DrawX=88,DrawY=88, sprite returns 3,5,7 -> sprite_addr 0, sprite_dir 3, red/green/blue 3,5,7 two Clk later.
REQ-035 Sprite returns F,0,F at DrawX=111,DrawY=111 with bg 1,2,3 -> sprite_addr 575, output 1,2,3; DrawX=112 -> no hit, sprite_addr 0.
REQ-036 Snake0 active right, keycode 16'h0004 (left) -> pending unchanged; keycode 16'h001A then frame origin -> dir_state[1:0] becomes 0 only at DrawX=DrawY=0.
REQ-037 Snakes 0 and 1 both at (200,200), both alive -> sprite_sel 0; snake_alive=2'b10 -> sprite_sel 1.
REQ-038 Snake0 at (5,5), DrawX=0,DrawY=0 -> hit, sprite_addr 7*24+7=175; DrawX=1023 -> no hit.
REQ-039 blank=0 during a hit -> output 0,0,0 two Clk later; Reset_n pulsed low mid-line -> outputs 0 immediately.

Source files
------------

// File: rtl/snake_sprite_if.sv
// Shared head-sprite memory port: the compositor issues address/direction/snake select
// and gets back the texel colour one clock later.
interface snake_sprite_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] sprite_addr;
  logic [1:0]        sprite_dir;
  logic [1:0]        sprite_sel;
  logic [3:0]        sprite_red;
  logic [3:0]        sprite_green;
  logic [3:0]        sprite_blue;

  modport master (
    output sprite_addr, sprite_dir, sprite_sel,
    input  sprite_red, sprite_green, sprite_blue
  );

  modport slave (
    input  sprite_addr, sprite_dir, sprite_sel,
    output sprite_red, sprite_green, sprite_blue
  );
endinterface

// File: rtl/snake_sprite_compositor.sv
// Composites up to four keyboard-steered snake head sprites over a background pixel
// stream with a two-clock pipeline and a magenta (F,0,F) transparency key.
module snake_sprite_compositor #(
  parameter int NUM_SNAKES = 2,
  parameter int SPRITE_DIM = 24,
  parameter int COORD_W    = 10,
  parameter int ADDR_W     = $clog2(SPRITE_DIM*SPRITE_DIM)
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [15:0]                   keycode,
  input  logic [COORD_W-1:0]            DrawX,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic                          blank,
  input  logic [NUM_SNAKES*COORD_W-1:0] snake_x,
  input  logic [NUM_SNAKES*COORD_W-1:0] snake_y,
  input  logic [NUM_SNAKES-1:0]         snake_alive,
  input  logic [3:0]                    bg_red,
  input  logic [3:0]                    bg_green,
  input  logic [3:0]                    bg_blue,
  snake_sprite_if.master                spr,
  output logic [3:0]                    red,
  output logic [3:0]                    green,
  output logic [3:0]                    blue,
  output logic [2*NUM_SNAKES-1:0]       dir_state
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] snake;
    dir_e       dir;
  } key_req_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COLOUR_KEY = '{r: 4'hF, g: 4'h0, b: 4'hF};
  // Reset orientation, snake i at [2*i +: 2]: snake0 right, 1 left, 2 down, 3 up.
  localparam logic [7:0] RESET_DIRS = {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};

  localparam int HALF_I = SPRITE_DIM / 2;
  localparam logic signed [COORD_W:0] HIT_LO = (COORD_W+1)'(-HALF_I);
  localparam logic signed [COORD_W:0] HIT_HI = (COORD_W+1)'(HALF_I - 1);

  function automatic key_req_t decode_key(input logic [7:0] code);
    key_req_t req;
    req = '{valid: 1'b0, snake: 2'd0, dir: DIR_UP};
    case (code)
      8'h1A: req = '{1'b1, 2'd0, DIR_UP};
      8'h04: req = '{1'b1, 2'd0, DIR_LEFT};
      8'h16: req = '{1'b1, 2'd0, DIR_DOWN};
      8'h07: req = '{1'b1, 2'd0, DIR_RIGHT};
      8'h52: req = '{1'b1, 2'd1, DIR_UP};
      8'h50: req = '{1'b1, 2'd1, DIR_LEFT};
      8'h51: req = '{1'b1, 2'd1, DIR_DOWN};
      8'h4F: req = '{1'b1, 2'd1, DIR_RIGHT};
      8'h0C: req = '{1'b1, 2'd2, DIR_UP};
      8'h0D: req = '{1'b1, 2'd2, DIR_LEFT};
      8'h0E: req = '{1'b1, 2'd2, DIR_DOWN};
      8'h0F: req = '{1'b1, 2'd2, DIR_RIGHT};
      8'h60: req = '{1'b1, 2'd3, DIR_UP};
      8'h5C: req = '{1'b1, 2'd3, DIR_LEFT};
      8'h5A: req = '{1'b1, 2'd3, DIR_DOWN};
      8'h5E: req = '{1'b1, 2'd3, DIR_RIGHT};
      default: req = '{valid: 1'b0, snake: 2'd0, dir: DIR_UP};
    endcase
    if (int'(req.snake) >= NUM_SNAKES) req.valid = 1'b0;
    return req;
  endfunction

  dir_e                  pending [NUM_SNAKES];
  dir_e                  active  [NUM_SNAKES];
  dir_e                  key_dir [NUM_SNAKES];
  logic [NUM_SNAKES-1:0] key_load;
  key_req_t              req_lo;
  key_req_t              req_hi;
  logic                  frame_origin;

  assign req_lo       = decode_key(keycode[7:0]);
  assign req_hi       = decode_key(keycode[15:8]);
  assign frame_origin = (DrawX == '0) && (DrawY == '0);

  // NOTE: every variable gets its default before any condition so no path infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_SNAKES; i++) begin
      key_load[i] = 1'b0;
      key_dir[i]  = pending[i];
      if (req_lo.valid && req_lo.snake == 2'(i)) begin
        key_load[i] = 1'b1;
        key_dir[i]  = req_lo.dir;
      end else if (req_hi.valid && req_hi.snake == 2'(i)) begin
        key_load[i] = 1'b1;
        key_dir[i]  = req_hi.dir;
      end
      // Opposite directions differ only in bit 1; a reversal request is dropped.
      if (key_dir[i] == dir_e'(active[i] ^ 2'd2)) key_load[i] = 1'b0;
    end
  end

  // NOTE: non-blocking so the frame-origin load sees pending as it was before this edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SNAKES; i++) begin
        pending[i] <= dir_e'(RESET_DIRS[2*i +: 2]);
        active[i]  <= dir_e'(RESET_DIRS[2*i +: 2]);
      end
    end else begin
      for (int i = 0; i < NUM_SNAKES; i++) begin
        if (key_load[i])  pending[i] <= key_dir[i];
        if (frame_origin) active[i]  <= pending[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SNAKES; i++) dir_state[2*i +: 2] = active[i];
  end

  // Signed offsets relative to each head centre; one extra bit keeps edge heads from wrapping.
  logic signed [COORD_W:0] dx [NUM_SNAKES];
  logic signed [COORD_W:0] dy [NUM_SNAKES];
  logic [NUM_SNAKES-1:0]   hit;
  logic                    any_hit;
  logic [ADDR_W-1:0]       off_x;
  logic [ADDR_W-1:0]       off_y;
  logic [1:0]              sel;
  dir_e                    sel_dir;

  always_comb begin
    for (int i = 0; i < NUM_SNAKES; i++) begin
      dx[i]  = $signed({1'b0, DrawX}) - $signed({1'b0, snake_x[i*COORD_W +: COORD_W]});
      dy[i]  = $signed({1'b0, DrawY}) - $signed({1'b0, snake_y[i*COORD_W +: COORD_W]});
      hit[i] = snake_alive[i] && (dx[i] >= HIT_LO) && (dx[i] <= HIT_HI)
                              && (dy[i] >= HIT_LO) && (dy[i] <= HIT_HI);
    end
  end

  // Walk downward so the lowest-index hitting snake is the one left selected.
  always_comb begin
    any_hit = 1'b0;
    sel     = 2'd0;
    sel_dir = DIR_UP;
    off_x   = '0;
    off_y   = '0;
    for (int i = NUM_SNAKES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel     = 2'(i);
        sel_dir = active[i];
        off_x   = ADDR_W'($unsigned(dx[i] - HIT_LO));
        off_y   = ADDR_W'($unsigned(dy[i] - HIT_LO));
      end
    end
    spr.sprite_addr = any_hit ? (off_y * ADDR_W'(SPRITE_DIM) + off_x) : '0;
    spr.sprite_dir  = any_hit ? sel_dir : DIR_UP;
    spr.sprite_sel  = any_hit ? sel : 2'd0;
  end

  // Stage 1 aligns hit/blank/bg with the sprite memory's one-clock read latency.
  logic hit_q;
  logic blank_q;
  rgb_t bg_q;
  rgb_t pix_q;
  rgb_t sprite_pix;

  assign sprite_pix = '{r: spr.sprite_red, g: spr.sprite_green, b: spr.sprite_blue};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_q   <= 1'b0;
      blank_q <= 1'b0;
      bg_q    <= '0;
      pix_q   <= '0;
    end else begin
      hit_q   <= any_hit;
      blank_q <= blank;
      bg_q    <= '{r: bg_red, g: bg_green, b: bg_blue};
      if (!blank_q)                              pix_q <= '0;
      else if (hit_q && sprite_pix != COLOUR_KEY) pix_q <= sprite_pix;
      else                                       pix_q <= bg_q;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

endmodule

// File: tb/tb_snake_sprite_compositor.sv
// Scoreboard bench: a reference model predicts each pixel when it is driven and the
// prediction is compared when the pixel leaves the two-clock pipeline.
module tb_snake_sprite_compositor;
  localparam int N   = 2;
  localparam int DIM = 24;
  localparam int CW  = 10;
  localparam int AW  = $clog2(DIM*DIM);

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [15:0]     keycode;
  logic [CW-1:0]   DrawX, DrawY;
  logic            blank;
  logic [N*CW-1:0] snake_x, snake_y;
  logic [N-1:0]    snake_alive;
  logic [3:0]      bg_red, bg_green, bg_blue;
  logic [3:0]      red, green, blue;
  logic [2*N-1:0]  dir_state;

  snake_sprite_if #(.ADDR_W(AW)) spr ();

  snake_sprite_compositor #(
    .NUM_SNAKES(N), .SPRITE_DIM(DIM), .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .snake_x(snake_x), .snake_y(snake_y), .snake_alive(snake_alive),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .spr(spr),
    .red(red), .green(green), .blue(blue), .dir_state(dir_state)
  );

  always #5 Clk = ~Clk;

  // Reference key table: rows are snakes, columns up/left/down/right.
  logic [7:0] key_tab [4][4] = '{
    '{8'h1A, 8'h04, 8'h16, 8'h07},
    '{8'h52, 8'h50, 8'h51, 8'h4F},
    '{8'h0C, 8'h0D, 8'h0E, 8'h0F},
    '{8'h60, 8'h5C, 8'h5A, 8'h5E}
  };

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q [$];
  logic [1:0]  m_pend [N];
  logic [1:0]  m_act  [N];
  logic [CW-1:0] cfg_x [N];
  logic [CW-1:0] cfg_y [N];
  logic [N-1:0]  cfg_alive;

  function automatic logic [11:0] rom_pix(input logic [AW-1:0] a, input logic [1:0] d,
                                          input logic [1:0] s);
    if (a == 0) return 12'h357;
    if (a == 575 || a[2:0] == 3'd5) return 12'hF0F;
    return {a[3:0], a[7:4] ^ {s, d}, {2'b00, a[9:8]}};
  endfunction

  // Sprite memory model: registered read, one clock of latency.
  always @(posedge Clk) begin
    logic [11:0] p;
    p = rom_pix(spr.sprite_addr, spr.sprite_dir, spr.sprite_sel);
    spr.sprite_red   <= p[11:8];
    spr.sprite_green <= p[7:4];
    spr.sprite_blue  <= p[3:0];
  end

  function automatic int key_snake(input logic [7:0] code, output logic [1:0] d);
    d = 2'd0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        if (s < N && code != 8'h00 && key_tab[s][k] == code) begin
          d = 2'(k);
          return s;
        end
    return -1;
  endfunction

  function automatic bit is_reverse(input logic [1:0] req, input logic [1:0] cur);
    return (req == 2'd0 && cur == 2'd2) || (req == 2'd2 && cur == 2'd0) ||
           (req == 2'd1 && cur == 2'd3) || (req == 2'd3 && cur == 2'd1);
  endfunction

  task automatic step(input int x, input int y, input logic b, input logic [11:0] bg,
                      input logic [15:0] key);
    int          hs, ex, ey;
    logic [AW-1:0] ea;
    logic [1:0]  ed, es, dlo, dhi;
    logic [11:0] pix, got;
    logic [2*N-1:0] md;
    logic [1:0]  np [N];
    @(negedge Clk);
    if (exp_q.size() == 2) begin
      got = {red, green, blue};
      vectors++;
      if (got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL pixel_out: got %h expected %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    for (int s = 0; s < N; s++) md[2*s +: 2] = m_act[s];
    vectors++;
    if (dir_state !== md) begin
      miscompares++;
      $display("FAIL dir_state: got %b expected %b", dir_state, md);
    end
    DrawX = CW'(x); DrawY = CW'(y); blank = b; keycode = key;
    {bg_red, bg_green, bg_blue} = bg;
    for (int s = 0; s < N; s++) begin
      snake_x[s*CW +: CW] = cfg_x[s];
      snake_y[s*CW +: CW] = cfg_y[s];
    end
    snake_alive = cfg_alive;
    hs = -1; ex = 0; ey = 0;
    for (int i = N - 1; i >= 0; i--) begin
      int dx, dy;
      dx = x - int'(cfg_x[i]);
      dy = y - int'(cfg_y[i]);
      if (cfg_alive[i] && dx >= -DIM/2 && dx < DIM/2 && dy >= -DIM/2 && dy < DIM/2) begin
        hs = i; ex = dx; ey = dy;
      end
    end
    ea = (hs < 0) ? '0 : AW'((ey + DIM/2) * DIM + ex + DIM/2);
    ed = (hs < 0) ? 2'd0 : m_act[hs];
    es = (hs < 0) ? 2'd0 : 2'(hs);
    #1;
    vectors++;
    if (spr.sprite_addr !== ea || spr.sprite_dir !== ed || spr.sprite_sel !== es) begin
      miscompares++;
      $display("FAIL sprite_bus at (%0d,%0d): got addr %0d dir %0d sel %0d expected %0d %0d %0d",
               x, y, spr.sprite_addr, spr.sprite_dir, spr.sprite_sel, ea, ed, es);
    end
    pix = rom_pix(ea, ed, es);
    if (!b)                            exp_q.push_back(12'h000);
    else if (hs >= 0 && pix != 12'hF0F) exp_q.push_back(pix);
    else                               exp_q.push_back(bg);
    for (int s = 0; s < N; s++) begin
      int  sl, sh;
      bit  have;
      logic [1:0] d;
      sl = key_snake(key[7:0], dlo);
      sh = key_snake(key[15:8], dhi);
      have = 1'b0; d = 2'd0;
      if (sl == s) begin have = 1'b1; d = dlo; end
      else if (sh == s) begin have = 1'b1; d = dhi; end
      np[s] = (have && !is_reverse(d, m_act[s])) ? d : m_pend[s];
    end
    if (x == 0 && y == 0) for (int s = 0; s < N; s++) m_act[s] = m_pend[s];
    for (int s = 0; s < N; s++) m_pend[s] = np[s];
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++;
    if ({red, green, blue} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
    end
    vectors++;
    if (dir_state !== 4'b0111) begin
      miscompares++;
      $display("FAIL reset_dir: got %b expected 0111", dir_state);
    end
    m_pend[0] = 2'd3; m_act[0] = 2'd3;
    m_pend[1] = 2'd1; m_act[1] = 2'd1;
    exp_q.delete();
    blank = 1'b0; keycode = 16'h0000; DrawX = CW'(1); DrawY = CW'(1);
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
  endtask

  task automatic check_dir_after_edge(input logic [2*N-1:0] want, input string tag);
    @(posedge Clk);
    #1;
    vectors++;
    if (dir_state !== want) begin
      miscompares++;
      $display("FAIL %s: dir_state %b expected %b", tag, dir_state, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic_hit();
    cfg_x[0] = 100; cfg_y[0] = 100; cfg_alive = 2'b01;
    step(88, 88, 1'b1, 12'h123, 16'h0000);
    vectors++;
    if (spr.sprite_addr !== 0 || spr.sprite_dir !== 2'd3) begin
      miscompares++;
      $display("FAIL basic_addr: addr %0d dir %0d expected 0 3", spr.sprite_addr, spr.sprite_dir);
    end
    step(89, 88, 1'b1, 12'h123, 16'h0000);
    step(90, 88, 1'b1, 12'h123, 16'h0000);
    vectors++;
    if ({red, green, blue} !== 12'h357) begin
      miscompares++;
      $display("FAIL basic_rgb: got %h expected 357", {red, green, blue});
    end
  endtask

  task automatic test_transparent();
    step(111, 111, 1'b1, 12'h123, 16'h0000);
    vectors++;
    if (spr.sprite_addr !== 575) begin
      miscompares++;
      $display("FAIL key_addr: got %0d expected 575", spr.sprite_addr);
    end
    step(112, 111, 1'b1, 12'h456, 16'h0000);
    vectors++;
    if (spr.sprite_addr !== 0 || spr.sprite_sel !== 0) begin
      miscompares++;
      $display("FAIL edge_nohit: addr %0d sel %0d expected 0 0", spr.sprite_addr, spr.sprite_sel);
    end
    step(113, 111, 1'b1, 12'h789, 16'h0000);
    vectors++;
    if ({red, green, blue} !== 12'h123) begin
      miscompares++;
      $display("FAIL key_rgb: got %h expected 123", {red, green, blue});
    end
  endtask

  task automatic test_keys();
    step(50, 50, 1'b1, 12'h111, 16'h0004);
    step(0, 0, 1'b1, 12'h111, 16'h0000);
    check_dir_after_edge(4'b0111, "reverse_ignored");
    step(50, 50, 1'b1, 12'h111, 16'h001A);
    check_dir_after_edge(4'b0111, "hold_until_origin");
    step(0, 0, 1'b1, 12'h111, 16'h0000);
    check_dir_after_edge(4'b0100, "load_at_origin");
    step(60, 60, 1'b1, 12'h222, 16'h0407);
    step(61, 60, 1'b1, 12'h222, 16'h5052);
    step(0, 0, 1'b1, 12'h222, 16'h0000);
    check_dir_after_edge(4'b0011, "low_byte_wins");
  endtask

  task automatic test_overlap();
    cfg_x[0] = 200; cfg_y[0] = 200; cfg_x[1] = 200; cfg_y[1] = 200; cfg_alive = 2'b11;
    step(200, 200, 1'b1, 12'h333, 16'h0000);
    vectors++;
    if (spr.sprite_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL overlap_both: sel %0d expected 0", spr.sprite_sel);
    end
    cfg_alive = 2'b10;
    step(201, 200, 1'b1, 12'h333, 16'h0000);
    vectors++;
    if (spr.sprite_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL overlap_dead0: sel %0d expected 1", spr.sprite_sel);
    end
  endtask

  task automatic test_clip();
    cfg_x[0] = 5; cfg_y[0] = 5; cfg_alive = 2'b01;
    step(0, 0, 1'b1, 12'h444, 16'h0000);
    vectors++;
    if (spr.sprite_addr !== 175) begin
      miscompares++;
      $display("FAIL clip_origin: addr %0d expected 175", spr.sprite_addr);
    end
    step(1023, 0, 1'b1, 12'h444, 16'h0000);
    vectors++;
    if (spr.sprite_addr !== 0) begin
      miscompares++;
      $display("FAIL clip_nowrap: addr %0d expected 0", spr.sprite_addr);
    end
  endtask

  task automatic test_blank();
    cfg_x[0] = 100; cfg_y[0] = 100; cfg_alive = 2'b01;
    step(100, 100, 1'b0, 12'h555, 16'h0000);
    step(101, 100, 1'b1, 12'h555, 16'h0000);
    step(88, 88, 1'b1, 12'h555, 16'h0000);
    vectors++;
    if ({red, green, blue} !== 12'h000) begin
      miscompares++;
      $display("FAIL blank_rgb: got %h expected 000", {red, green, blue});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] keys [10] = '{16'h0000, 16'h0004, 16'h0007, 16'h001A, 16'h0016,
                               16'h5000, 16'h5152, 16'h4F00, 16'h0C60, 16'h0450};
    cfg_x[0] = 300; cfg_y[0] = 200; cfg_x[1] = 310; cfg_y[1] = 205; cfg_alive = 2'b11;
    for (int n = 0; n < 150; n++) begin
      if (n % 25 == 24)
        step(0, 0, 1'b1, 12'(($urandom)), 16'h0000);
      else
        step($urandom_range(284, 330), $urandom_range(186, 220),
             ($urandom_range(0, 7) != 0), 12'($urandom), keys[$urandom_range(0, 9)]);
    end
  endtask

  task automatic test_reset_midline();
    cfg_x[0] = 100; cfg_y[0] = 100; cfg_alive = 2'b01;
    step(88, 88, 1'b1, 12'h666, 16'h001A);
    step(88, 88, 1'b1, 12'h666, 16'h0000);
    step(88, 88, 1'b1, 12'h666, 16'h0000);
    do_reset();
    step(88, 88, 1'b1, 12'h777, 16'h0000);
    step(111, 111, 1'b1, 12'h777, 16'h0000);
    step(300, 300, 1'b1, 12'h777, 16'h0000);
    step(301, 300, 1'b1, 12'h777, 16'h0000);
  endtask

  initial begin
    blank = 1'b0; keycode = 16'h0000; DrawX = '0; DrawY = CW'(1);
    {bg_red, bg_green, bg_blue} = 12'h000;
    snake_x = '0; snake_y = '0; snake_alive = '0;
    cfg_x[0] = 0; cfg_y[0] = 0; cfg_x[1] = 0; cfg_y[1] = 0; cfg_alive = '0;
    #3;
    test_reset();
    test_basic_hit();
    test_transparent();
    test_keys();
    test_overlap();
    test_clip();
    test_blank();
    test_back_to_back();
    test_reset_midline();
    step(500, 500, 1'b0, 12'h000, 16'h0000);
    step(501, 500, 1'b0, 12'h000, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
